// File: rtl/edge_win_buffer.sv
// 3x3 sliding-window generator for the edge-detection datapath.
// Optional stall counter: define EDGE_WIN_STALL_CNT_EN.
module edge_win_buffer #(
    parameter int PixelWidth  = 8,
    parameter int MaxImgWidth = 64,
    localparam int DimWidth   = $clog2(MaxImgWidth + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [DimWidth-1:0]     cfg_width_i,
    input  logic [15:0]             cfg_height_i,
    output logic                    cfg_err_o,
    output logic                    busy_o,
    output logic                    frame_done_o,
    input  logic                    pix_valid_i,
    output logic                    pix_ready_o,
    input  logic [PixelWidth-1:0]   pix_data_i,
    output logic                    win_valid_o,
    input  logic                    win_ready_i,
    output logic [9*PixelWidth-1:0] win_data_o,
    output logic [15:0]             win_row_o,
    output logic [DimWidth-1:0]     win_col_o,
    output logic [31:0]             stall_cnt_o
);

    localparam int AddrWidth = $clog2(MaxImgWidth);
    localparam int PW = PixelWidth;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t state, state_nxt;

    logic [DimWidth-1:0]  width_q;
    logic [DimWidth-1:0]  col;
    logic [15:0]          height_q;
    logic [15:0]          row;
    logic [AddrWidth-1:0] addr;

    logic [PW-1:0] lb0 [MaxImgWidth];
    logic [PW-1:0] lb1 [MaxImgWidth];
    logic [PW-1:0] top;
    logic [PW-1:0] mid;

    logic [9*PW-1:0] win_q;
    logic [9*PW-1:0] win_nxt;

    logic cfg_ok;
    logic start_ok;
    logic pix_ready;
    logic accept;
    logic col_last;
    logic row_last;
    logic emit;
    logic hand_off;

    assign cfg_ok = (cfg_width_i >= DimWidth'(3))
                 && (cfg_width_i <= DimWidth'(MaxImgWidth))
                 && (cfg_height_i >= 16'd3);

    assign start_ok  = (state == IDLE) && start_i && cfg_ok;
    assign hand_off  = win_valid_o && win_ready_i;
    assign pix_ready = (state == RUN) && (!win_valid_o || win_ready_i);
    assign accept    = pix_ready && pix_valid_i;

    assign addr     = col[AddrWidth-1:0];
    assign top      = lb0[addr];
    assign mid      = lb1[addr];
    assign col_last = (col == width_q - DimWidth'(1));
    assign row_last = (row == height_q - 16'd1);
    assign emit     = accept && (row >= 16'd2) && (col >= DimWidth'(2));

    assign busy_o      = (state != IDLE);
    assign pix_ready_o = pix_ready;

    // Shift every window row left; the new right column is the
    // vertical slice {two rows back, one row back, incoming pixel}.
    always_comb begin
        win_nxt = win_q;
        for (int r = 0; r < 3; r++) begin
            win_nxt[PW*(3*r)   +: PW] = win_q[PW*(3*r+1) +: PW];
            win_nxt[PW*(3*r+1) +: PW] = win_q[PW*(3*r+2) +: PW];
        end
        win_nxt[PW*2 +: PW] = top;
        win_nxt[PW*5 +: PW] = mid;
        win_nxt[PW*8 +: PW] = pix_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (accept && row_last && col_last) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (hand_off) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            width_q   <= '0;
            height_q  <= '0;
            col       <= '0;
            row       <= '0;
            cfg_err_o <= 1'b0;
        end else begin
            if ((state == IDLE) && start_i) begin
                cfg_err_o <= !cfg_ok;
                if (cfg_ok) begin
                    width_q  <= cfg_width_i;
                    height_q <= cfg_height_i;
                    col      <= '0;
                    row      <= '0;
                end
            end else if (accept) begin
                if (col_last) begin
                    col <= '0;
                    row <= row + 16'd1;
                end else begin
                    col <= col + DimWidth'(1);
                end
            end
        end
    end

    // Line buffers carry no reset; a stale row is always overwritten
    // twice before it can reach the emitted top row.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            lb0[addr] <= lb1[addr];
            lb1[addr] <= pix_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_q <= '0;
        end else if (accept) begin
            win_q <= win_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_valid_o  <= 1'b0;
            win_data_o   <= '0;
            win_row_o    <= '0;
            win_col_o    <= '0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= (state == FLUSH) && hand_off;
            if (emit) begin
                win_valid_o <= 1'b1;
                win_data_o  <= win_nxt;
                win_row_o   <= row - 16'd1;
                win_col_o   <= col - DimWidth'(1);
            end else if (win_ready_i) begin
                win_valid_o <= 1'b0;
            end
        end
    end

`ifdef EDGE_WIN_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt <= '0;
        end else if (start_ok) begin
            stall_cnt <= '0;
        end else if ((state != IDLE) && win_valid_o && !win_ready_i
                     && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`else
    assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_edge_win_buffer.sv
// Self-checking bench for edge_win_buffer: directed frames plus a
// randomized handshake frame against a window reference model.
module tb_edge_win_buffer;

    localparam int PW = 8;
    localparam int DW = 7;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [DW-1:0]  cfg_w = '0;
    logic [15:0]    cfg_h = '0;
    logic           cfg_err;
    logic           busy;
    logic           frame_done;
    logic           pix_valid = 1'b0;
    logic           pix_ready;
    logic [PW-1:0]  pix_data = '0;
    logic           win_valid;
    logic           win_ready = 1'b1;
    logic [9*PW-1:0] win_data;
    logic [15:0]    win_row;
    logic [DW-1:0]  win_col;
    logic [31:0]    stall_cnt;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    logic [7:0]  img [0:1023];
    logic [94:0] wq [$];
    logic        hold = 1'b0;
    logic [94:0] hdat;

    edge_win_buffer dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .cfg_width_i  (cfg_w),
        .cfg_height_i (cfg_h),
        .cfg_err_o    (cfg_err),
        .busy_o       (busy),
        .frame_done_o (frame_done),
        .pix_valid_i  (pix_valid),
        .pix_ready_o  (pix_ready),
        .pix_data_i   (pix_data),
        .win_valid_o  (win_valid),
        .win_ready_i  (win_ready),
        .win_data_o   (win_data),
        .win_row_o    (win_row),
        .win_col_o    (win_col),
        .stall_cnt_o  (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Observer: collects handed-off windows and checks hold-under-stall.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("hold_valid", 128'(win_valid), 128'(1));
                check("hold_data", 128'({win_row, win_col, win_data}),
                      128'(hdat));
            end
            if (win_valid && !win_ready) begin
                check("stall_pix_ready", 128'(pix_ready), 128'(0));
                hold = 1'b1;
                hdat = {win_row, win_col, win_data};
            end else begin
                hold = 1'b0;
            end
            if (win_valid && win_ready) wq.push_back({win_row, win_col, win_data});
            if (frame_done) done_cnt++;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int w, input int h);
        start = 1'b1;
        cfg_w = DW'(w);
        cfg_h = 16'(h);
        cycle();
        start = 1'b0;
    endtask

    // pol: 0 = always ready, 1 = random valid/ready, 2 = stall 2nd window 5 cycles
    task automatic run_frame(input int w, input int h, input int pol);
        int idx = 0;
        int cyc = 0;
        int d0 = done_cnt;
        int stalled = 0;
        logic fire;
        while (done_cnt == d0 && cyc < 4000) begin
            pix_valid = (idx < w * h) && (pol != 1 || $urandom_range(0, 3) != 0);
            pix_data = (idx < w * h) ? img[idx] : 8'h00;
            if (pol == 1) begin
                win_ready = ($urandom_range(0, 2) != 0);
            end else if (pol == 2 && win_valid && wq.size() == 1 && stalled < 5) begin
                win_ready = 1'b0;
                stalled++;
            end else begin
                win_ready = 1'b1;
            end
            @(negedge clk);
            fire = pix_valid && pix_ready;
            cycle();
            if (fire) idx++;
            cyc++;
        end
        pix_valid = 1'b0;
        win_ready = 1'b1;
        check("frame_timeout", 128'(done_cnt != d0), 128'(1));
    endtask

    // Expected windows: every interior centre in raster order.
    task automatic check_frame(input int w, input int h, input int d0);
        int n;
        int r;
        int c;
        logic [9*PW-1:0] exp;
        repeat (3) cycle();
        n = (w - 2) * (h - 2);
        check("win_count", 128'(wq.size()), 128'(n));
        check("done_pulses", 128'(done_cnt - d0), 128'(1));
        check("busy_after", 128'(busy), 128'(0));
        for (int k = 0; k < n && k < wq.size(); k++) begin
            r = 1 + k / (w - 2);
            c = 1 + k % (w - 2);
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    exp[PW*(3*i+j) +: PW] = img[(r - 1 + i) * w + c - 1 + j];
            check("win_word", 128'(wq[k]), 128'({16'(r), DW'(c), exp}));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 128'(win_valid), 128'(0));
        check({tag, "_pready"}, 128'(pix_ready), 128'(0));
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_err"}, 128'(cfg_err), 128'(0));
        check({tag, "_done"}, 128'(frame_done), 128'(0));
        check({tag, "_data"}, 128'({win_row, win_col, win_data}), 128'(0));
        check({tag, "_stall"}, 128'(stall_cnt), 128'(0));
    endtask

    task automatic check_fixed(input int k, input int b0, input int row, input int col);
        logic [9*PW-1:0] exp;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                exp[PW*(3*i+j) +: PW] = 8'(b0 + 4 * i + j);
        check("fixed_win", 128'(wq[k]), 128'({16'(row), DW'(col), exp}));
    endtask

    initial begin
        int d0;
        int exp_stall;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_idle_outputs("reset");
        cycle();
        rst_n = 1'b1;
        cycle();
        check_idle_outputs("post_reset");

        // 4x4 raster 0..15, always ready
        for (int i = 0; i < 16; i++) img[i] = 8'(i);
        wq.delete();
        do_start(4, 4);
        check("busy_run", 128'(busy), 128'(1));
        d0 = done_cnt;
        run_frame(4, 4, 0);
        check_frame(4, 4, d0);
        if (wq.size() == 4) begin
            check_fixed(0, 0, 1, 1);
            check_fixed(3, 5, 2, 2);
        end else begin
            check("fixed_count", 128'(wq.size()), 128'(4));
        end

        // same frame, second window stalled 5 cycles
        wq.delete();
        do_start(4, 4);
        d0 = done_cnt;
        run_frame(4, 4, 2);
        check_frame(4, 4, d0);
`ifdef EDGE_WIN_STALL_CNT_EN
        exp_stall = 5;
`else
        exp_stall = 0;
`endif
        check("stall_cnt", 128'(stall_cnt), 128'(exp_stall));

        // bad geometries
        do_start(2, 4);
        check("err_w2", 128'(cfg_err), 128'(1));
        check("err_w2_busy", 128'(busy), 128'(0));
        pix_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("err_pready", 128'(pix_ready), 128'(0));
            cycle();
        end
        pix_valid = 1'b0;
        do_start(65, 4);
        check("err_w65", 128'(cfg_err), 128'(1));
        check("err_w65_busy", 128'(busy), 128'(0));
        do_start(4, 2);
        check("err_h2", 128'(cfg_err), 128'(1));
        check("err_h2_pready", 128'(pix_ready), 128'(0));

        // recovery with 5x3
        for (int i = 0; i < 15; i++) img[i] = 8'($urandom_range(0, 255));
        wq.delete();
        do_start(5, 3);
        check("err_cleared", 128'(cfg_err), 128'(0));
        check("busy_5x3", 128'(busy), 128'(1));
        d0 = done_cnt;
        run_frame(5, 3, 0);
        check_frame(5, 3, d0);

        // full width 64x3
        for (int i = 0; i < 192; i++) img[i] = 8'(i % 256);
        wq.delete();
        do_start(64, 3);
        d0 = done_cnt;
        run_frame(64, 3, 0);
        check_frame(64, 3, d0);

        // reset after 6 pixels
        for (int i = 0; i < 16; i++) img[i] = 8'(i);
        wq.delete();
        do_start(4, 4);
        pix_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pix_data = img[i];
            cycle();
        end
        pix_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        cycle();
        rst_n = 1'b1;
        cycle();
        check_idle_outputs("after_mid_reset");
        wq.delete();
        do_start(4, 4);
        d0 = done_cnt;
        run_frame(4, 4, 0);
        check_frame(4, 4, d0);
        if (wq.size() == 4) begin
            check_fixed(0, 0, 1, 1);
            check_fixed(3, 5, 2, 2);
        end

        // random handshakes over 10x7
        for (int i = 0; i < 70; i++) img[i] = 8'($urandom_range(0, 255));
        wq.delete();
        do_start(10, 7);
        d0 = done_cnt;
        run_frame(10, 7, 1);
        check_frame(10, 7, d0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/edge_win_buffer.md
Name: edge_win_buffer

Overview:
Upstream feeder for the edge-detection accelerator in the user domain. It accepts a raster-order pixel stream and produces every interior 3x3 neighbourhood as one parallel window word, ready for the convolution datapath. Two on-chip line buffers hold the previous two image rows, and a 3x3 shift window holds the current neighbourhood. Frame geometry is loaded per frame from accelerator control registers.

Parameters:
PixelWidth, 8, bits per pixel
MaxImgWidth, 64, maximum image width in pixels; sets line-buffer depth
DimWidth, $clog2(MaxImgWidth+1), width of the geometry and coordinate fields (localparam, not overridable)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active low
start_i  in  1  one-cycle pulse: latch geometry and begin a frame
cfg_width_i  in  DimWidth  image width in pixels
cfg_height_i  in  16  image height in rows
cfg_err_o  out  1  sticky geometry error; cleared by the next valid start_i
busy_o  out  1  frame in progress
frame_done_o  out  1  one-cycle pulse after the last window is consumed
pix_valid_i  in  1  pixel handshake valid
pix_ready_o  out  1  pixel handshake ready
pix_data_i  in  PixelWidth  pixel value
win_valid_o  out  1  window handshake valid
win_ready_i  in  1  window handshake ready
win_data_o  out  9*PixelWidth  window; element (r,c) at bit offset PixelWidth*(3r+c); r=0 is the oldest row, c=0 is the leftmost column
win_row_o  out  16  row of the window centre pixel
win_col_o  out  DimWidth  column of the window centre pixel
stall_cnt_o  out  32  window backpressure cycle counter (see Optional Feature)

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Line-buffer contents are not reset.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - pix_ready_o=0.
  - On start_i with 3<=cfg_width_i<=MaxImgWidth and cfg_height_i>=3: latch the geometry, set col=0 and row=0, clear cfg_err_o, go to RUN.
  - On start_i with any other geometry: set cfg_err_o and stay in IDLE.
- busy_o=1 in RUN and FLUSH.
- start_i is ignored outside IDLE.
- RUN:
  - pix_ready_o = !win_valid_o || win_ready_i (single output register, full throughput).
  - Accepted pixel at column col updates: lb0[col]<=lb1[col]; lb1[col]<=pix; each window row shifts left by one; the new rightmost column is {lb0[col], lb1[col], pix} for r=0..2.
  - When the accepted pixel has row>=2 and col>=2, load the output register with the updated window. Set win_row_o=row-1 and win_col_o=col-1. Assert win_valid_o in the next cycle (1-cycle latency).
  - Otherwise, if win_ready_i is asserted, win_valid_o drops.
  - Column counter wraps from width-1 to 0 and increments the row counter. Windows that straddle a row boundary are never emitted because of the col>=2 rule.
  - On accepting pixel (height-1, width-1): go to FLUSH.
- FLUSH:
  - pix_ready_o=0.
  - When win_valid_o && win_ready_i: pulse frame_done_o, go to IDLE.
- Output stability: win_data_o, win_row_o and win_col_o are held stable while win_valid_o=1 and win_ready_i=0.
- Window count: exactly (W-2)*(H-2) windows are emitted per frame.
- Simultaneous hand-off and load: the output register may take the new window in the same cycle the old one is handed off.
- Reset mid-frame: returns to IDLE immediately; no frame_done_o pulse.

Optional Feature:
Macro EDGE_WIN_STALL_CNT_EN.
- Defined: stall_cnt_o counts cycles with win_valid_o=1 and win_ready_i=0. It clears on accepted start_i, saturates at 32'hFFFF_FFFF, and holds its value in IDLE.
- Not defined: the counter logic is absent and stall_cnt_o is tied to 0.

Test Plan:
- 4x4 frame with pixels 0..15 in raster order, win_ready_i=1: 4 windows.
  - First window = {0,1,2,4,5,6,8,9,10} at centre (1,1).
  - Last window = {5,6,7,9,10,11,13,14,15} at centre (2,2).
  - frame_done_o pulses once.
- Same frame with win_ready_i low for 5 cycles on the second window: pix_ready_o=0 during the stall, window content held stable, no loss or duplication; stall_cnt_o=5 with the macro defined, 0 without.
- start_i with cfg_width_i=2, or cfg_width_i=MaxImgWidth+1, or cfg_height_i=2: cfg_err_o=1, busy_o=0, pix_ready_o stays 0. A following start_i with 5x3 geometry clears cfg_err_o and produces 3 windows.
- Width 64, height 3, pixels p[i]=i mod 256: 62 windows. Window k has centre column k+1, and its top row is {k, k+1, k+2}. The top row must not contain pixels from a previous frame.
- Assert rst_ni for one cycle after 6 pixels of a 4x4 frame: all outputs return to 0. A new 4x4 frame then matches the first scenario exactly.
- Random pix_valid_i and win_ready_i over a 10x7 frame: 40 windows, matching a reference model, in raster order of their centres.
